// File: rtl/scaler_pkg.sv
// Shared constants for the zoom-engine sequencer: state encodings, command
// bit positions, framebuffer geometry and datapath widths.
package scaler_pkg;

    localparam int ADDR_W = 19;
    localparam int PIX_W  = 8;

    localparam int FB_WIDTH  = 640;
    localparam int FB_HEIGHT = 480;
    localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;

    // cmd_mode bit positions
    localparam int MODE_ZOOM_BIT     = 0;
    localparam int MODE_SKIP_CLR_BIT = 1;

    // Sequencer states
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLEAR  = 3'd1;
    localparam logic [2:0] ST_LAUNCH = 3'd2;
    localparam logic [2:0] ST_PRIME  = 3'd3;
    localparam logic [2:0] ST_RUN    = 3'd4;
    localparam logic [2:0] ST_ERROR  = 3'd5;

endpackage

// File: rtl/scaler_sequencer_fb_write_mux.sv
// fb_write_mux: registered framebuffer write port shared between the
// sequencer's clear writes and the engine's pixel stream.
module fb_write_mux
    import scaler_pkg::*;
#(
    parameter logic [PIX_W-1:0] CLEAR_VALUE = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_en,    // next cycle is a clear write
    input  logic [ADDR_W-1:0] clear_addr,
    input  logic              run_en,      // engine stream is being forwarded
    input  logic              run_we,      // forwarded beat is a real write
    input  logic [ADDR_W-1:0] eng_addr,
    input  logic [PIX_W-1:0]  eng_pixel,
    output logic [ADDR_W-1:0] ram_wraddr,
    output logic [PIX_W-1:0]  ram_wdata,
    output logic              ram_we
);

    logic [ADDR_W-1:0] wraddr_d, wraddr_q;
    logic [PIX_W-1:0]  wdata_d,  wdata_q;
    logic              we_d,     we_q;

    // Select the write source; address/data hold when nothing is writing
    always_comb begin
        wraddr_d = wraddr_q;
        wdata_d  = wdata_q;
        we_d     = 1'b0;
        if (clear_en) begin
            wraddr_d = clear_addr;
            wdata_d  = CLEAR_VALUE;
            we_d     = 1'b1;
        end else if (run_en) begin
            wraddr_d = eng_addr;
            wdata_d  = eng_pixel;
            we_d     = run_we;
        end
    end

    // Write-port registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wraddr_q <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
        end else begin
            wraddr_q <= wraddr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
        end
    end

    assign ram_wraddr = wraddr_q;
    assign ram_wdata  = wdata_q;
    assign ram_we     = we_q;

endmodule

// File: rtl/scaler_sequencer.sv
// scaler_sequencer: runs one clear + scaling pass of the zoom engine per
// accepted command and owns the framebuffer write port.
// Optional feature macro: SEQ_TIMEOUT_EN (RUN watchdog and ERROR state).
module scaler_sequencer
    import scaler_pkg::*;
#(
    parameter int               OUT_PIXELS     = FB_PIXELS,
    parameter logic [PIX_W-1:0] CLEAR_VALUE    = 8'h00,
    parameter int               TIMEOUT_CYCLES = 400000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_mode,
    output logic              cmd_ready,
    output logic              eng_rst,
    output logic              eng_sw,
    input  logic [ADDR_W-1:0] eng_addr,
    input  logic [PIX_W-1:0]  eng_pixel,
    input  logic              eng_done,
    output logic [ADDR_W-1:0] ram_wraddr,
    output logic [PIX_W-1:0]  ram_wdata,
    output logic              ram_we,
    output logic              busy,
    output logic              error
);

    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(OUT_PIXELS - 1);

    logic [2:0]        state_d, state_q;
    logic [ADDR_W-1:0] cnt_d, cnt_q;
    logic              eng_sw_d, eng_sw_q;
    logic              accept;
    logic              timeout_hit;

    assign accept = cmd_valid && (state_q == ST_IDLE);

    // Pass sequencing: next state, clear address counter, latched zoom factor
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        eng_sw_d = eng_sw_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    eng_sw_d = cmd_mode[MODE_ZOOM_BIT];
                    cnt_d    = '0;
                    state_d  = cmd_mode[MODE_SKIP_CLR_BIT] ? ST_LAUNCH : ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == CLR_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_LAUNCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LAUNCH: state_d = ST_PRIME;
            ST_PRIME:  state_d = ST_RUN;
            ST_RUN: begin
                // eng_done takes priority over a watchdog expiry in the same cycle
                if (eng_done) begin
                    state_d = ST_IDLE;
                end else if (timeout_hit) begin
                    state_d = ST_ERROR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            eng_sw_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            eng_sw_q <= eng_sw_d;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    logic [ADDR_W-1:0] run_cnt_d, run_cnt_q;
    logic              error_d, error_q;

    assign timeout_hit = (state_q == ST_RUN) &&
                         (run_cnt_q == ADDR_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: count RUN cycles from 0; error is sticky until the next accept
    always_comb begin
        run_cnt_d = (state_q == ST_RUN) ? run_cnt_q + 1'b1 : '0;
        error_d   = error_q;
        if (accept) begin
            error_d = 1'b0;
        end else if (timeout_hit && !eng_done) begin
            error_d = 1'b1;
        end
    end

    // Watchdog registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt_q <= '0;
            error_q   <= 1'b0;
        end else begin
            run_cnt_q <= run_cnt_d;
            error_q   <= error_d;
        end
    end

    assign error = error_q;
`else
    assign timeout_hit = 1'b0;
    assign error       = 1'b0;
`endif

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign eng_rst   = !((state_q == ST_PRIME) || (state_q == ST_RUN));
    assign eng_sw    = eng_sw_q;

    // Clear writes are keyed on the next state so the registered port lines up
    // with CLEAR itself; engine beats are forwarded one cycle late and only
    // written while RUN continues (not on the eng_done or watchdog cycle).
    fb_write_mux #(
        .CLEAR_VALUE (CLEAR_VALUE)
    ) u_fb_write_mux (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_en   (state_d == ST_CLEAR),
        .clear_addr (cnt_d),
        .run_en     (state_q == ST_RUN),
        .run_we     ((state_q == ST_RUN) && (state_d == ST_RUN)),
        .eng_addr   (eng_addr),
        .eng_pixel  (eng_pixel),
        .ram_wraddr (ram_wraddr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we)
    );

endmodule
